// File: rtl/pdu_pkg.sv
// rtl/pdu_pkg.sv - shared constants for the program-debug unit
package pdu_pkg;

  localparam logic [1:0] VIEW_OUT  = 2'd0;
  localparam logic [1:0] VIEW_BUF  = 2'd1;
  localparam logic [1:0] VIEW_PC   = 2'd2;
  localparam logic [1:0] VIEW_STEP = 2'd3;

  localparam int HEX_W      = 4;
  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/pdu_debounce.sv
// rtl/pdu_debounce.sv - synchroniser, vector debouncer and rising-edge pulse
module pdu_debounce
  import pdu_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] pe
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [SYNC_DEPTH-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                 s;
  logic [WIDTH-1:0]                 cand;
  logic [WIDTH-1:0]                 f_d;
  logic [CNT_W-1:0]                 cnt;

  assign s  = sync_q[SYNC_DEPTH-1];
  assign pe = f & ~f_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
    end
  end

  // cnt tracks how many consecutive samples have matched cand while differing from f
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      f    <= '0;
      f_d  <= '0;
      cnt  <= '0;
    end else begin
      f_d <= f;
      if (s == f) begin
        cnt <= '0;
      end else if (cnt != '0 && s == cand) begin
        if (cnt == CNT_W'(DB_CYCLES - 1)) begin
          f   <= s;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (DB_CYCLES <= 1) begin
        f <= s;
      end else begin
        cand <= s;
        cnt  <= CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pdu_debug_ctrl.sv
// rtl/pdu_debug_ctrl.sv - board-side debug unit: run/step control, hex I/O, display scan
module pdu_debug_ctrl
  import pdu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IN_W      = 5,
  parameter int OUT_W     = 5,
  parameter int DIGITS    = 8,
  parameter int DB_CYCLES = 4,
  parameter int SCAN_DIV  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       step,
  input  logic                       valid,
  input  logic [IN_W-1:0]            in,
  output logic [1:0]                 check,
  output logic [OUT_W-1:0]           out0,
  output logic [$clog2(DIGITS)-1:0]  an,
  output logic [HEX_W-1:0]           seg,
  output logic                       ready,
  output logic                       cpu_en,
  input  logic                       io_rd,
  output logic [DATA_W-1:0]          io_rd_data,
  input  logic                       io_wr,
  input  logic [DATA_W-1:0]          io_wr_data,
  input  logic [DATA_W-1:0]          dbg_pc
);

  localparam int AN_W  = $clog2(DIGITS);
  localparam int NDIG  = DATA_W / HEX_W;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [2:0]        btn_f;
  logic [2:0]        btn_pe;
  logic [IN_W-1:0]   in_f;
  logic [IN_W-1:0]   sw_pe;
  logic              run_f;
  logic              step_pe;
  logic              valid_pe;
  logic              unused_sig;

  logic [DATA_W-1:0] step_cnt;
  logic [DATA_W-1:0] in_buf;
  logic [DATA_W-1:0] buf_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] out_reg;
  logic              rd_ok;

  logic [DIV_W-1:0]  div;
  logic [AN_W-1:0]   an_n;
  logic [DATA_W-1:0] view;
  logic [DATA_W-1:0] view_sh;

  pdu_debounce #(.WIDTH(3), .DB_CYCLES(DB_CYCLES)) u_btn (
    .clk (clk),
    .rst (rst),
    .d   ({valid, step, run}),
    .f   (btn_f),
    .pe  (btn_pe)
  );

  pdu_debounce #(.WIDTH(IN_W), .DB_CYCLES(DB_CYCLES)) u_sw (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .f   (in_f),
    .pe  (sw_pe)
  );

  assign run_f      = btn_f[0];
  assign step_pe    = btn_pe[1];
  assign valid_pe   = btn_pe[2];
  assign unused_sig = ^{btn_pe[0], sw_pe, in_f};

  assign out0       = out_reg[OUT_W-1:0];
  assign rd_ok      = io_rd & ready;
  assign io_rd_data = rd_ok ? in_buf : '0;

  // A read clears first so a digit arriving in the same cycle starts a fresh word
  always_comb begin
    buf_n = in_buf;
    cnt_n = cnt;
    if (rd_ok) begin
      buf_n = '0;
      cnt_n = '0;
    end
    if (valid_pe && !in_f[IN_W-1]) begin
      buf_n = {buf_n[DATA_W-HEX_W-1:0], in_f[HEX_W-1:0]};
      if (cnt_n != CNT_W'(NDIG)) begin
        cnt_n = cnt_n + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_en   <= 1'b0;
      step_cnt <= '0;
      check    <= VIEW_OUT;
      in_buf   <= '0;
      cnt      <= '0;
      ready    <= 1'b0;
      out_reg  <= '0;
    end else begin
      cpu_en <= run_f | step_pe;
      if (cpu_en) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (valid_pe && in_f[IN_W-1]) begin
        check <= check + 2'd1;
      end
      in_buf <= buf_n;
      cnt    <= cnt_n;
      ready  <= (cnt_n != '0);
      if (io_wr) begin
        out_reg <= io_wr_data;
      end
    end
  end

  always_comb begin
    view = out_reg;
    case (check)
      VIEW_OUT:  view = out_reg;
      VIEW_BUF:  view = in_buf;
      VIEW_PC:   view = dbg_pc;
      VIEW_STEP: view = step_cnt;
      default:   view = out_reg;
    endcase
  end

  assign an_n    = (an == AN_W'(DIGITS - 1)) ? '0 : an + 1'b1;
  assign view_sh = view >> (HEX_W * an_n);

  // seg is loaded together with an, so a view change appears on the next digit
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      an  <= '0;
      seg <= '0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div <= '0;
      an  <= an_n;
      seg <= view_sh[HEX_W-1:0];
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: tb/tb_pdu_debug_ctrl.sv
// tb/tb_pdu_debug_ctrl.sv - self-checking bench for pdu_debug_ctrl
module tb_pdu_debug_ctrl;

  localparam int DATA_W    = 32;
  localparam int IN_W      = 5;
  localparam int OUT_W     = 5;
  localparam int DIGITS    = 8;
  localparam int DB_CYCLES = 4;
  localparam int SCAN_DIV  = 4;
  localparam int AN_W      = $clog2(DIGITS);
  localparam int NDIG      = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst, run, step, valid, io_rd, io_wr;
  logic [IN_W-1:0]   in;
  logic [DATA_W-1:0] io_wr_data, dbg_pc;
  logic [1:0]        check;
  logic [OUT_W-1:0]  out0;
  logic [AN_W-1:0]   an;
  logic [3:0]        seg;
  logic              ready, cpu_en;
  logic [DATA_W-1:0] io_rd_data;

  always #5 clk = ~clk;

  pdu_debug_ctrl #(
    .DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W), .DIGITS(DIGITS),
    .DB_CYCLES(DB_CYCLES), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .valid(valid), .in(in),
    .check(check), .out0(out0), .an(an), .seg(seg), .ready(ready), .cpu_en(cpu_en),
    .io_rd(io_rd), .io_rd_data(io_rd_data), .io_wr(io_wr), .io_wr_data(io_wr_data),
    .dbg_pc(dbg_pc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: board samples in a history queue, filtered values taken from
  // a uniform window of delayed samples, everything else as plain arithmetic.
  logic [7:0]        hist[$];
  logic [2:0]        m_bf, m_bfd;
  logic [IN_W-1:0]   m_if, m_ifd;
  logic              m_cpu_en;
  logic [31:0]       m_step_cnt, m_buf, m_out_reg;
  int                m_cnt, m_check, m_t, m_an;
  logic [3:0]        m_seg;
  logic [31:0]       rd_seen;

  task automatic model_reset();
    hist.delete();
    repeat (DB_CYCLES + 2) hist.push_back(8'h00);
    m_bf = '0; m_bfd = '0; m_if = '0; m_ifd = '0;
    m_cpu_en = 1'b0; m_step_cnt = '0; m_buf = '0; m_out_reg = '0;
    m_cnt = 0; m_check = 0; m_t = 0; m_an = 0; m_seg = '0;
  endtask

  task automatic model_edge();
    logic        step_p, valid_p, uni_b, uni_i;
    logic [31:0] v;
    if (rst) begin
      model_reset();
      return;
    end
    step_p  = m_bf[1] & ~m_bfd[1];
    valid_p = m_bf[2] & ~m_bfd[2];
    case (m_check)
      0: v = m_out_reg;
      1: v = m_buf;
      2: v = dbg_pc;
      default: v = m_step_cnt;
    endcase
    if (m_cpu_en) m_step_cnt = m_step_cnt + 1;
    m_cpu_en = m_bf[0] | step_p;
    if (io_rd && m_cnt != 0) begin
      m_buf = 0;
      m_cnt = 0;
    end
    if (valid_p) begin
      if (m_if[IN_W-1]) m_check = (m_check + 1) % 4;
      else begin
        m_buf = (m_buf << 4) | 32'(m_if[3:0]);
        m_cnt = (m_cnt + 1 > NDIG) ? NDIG : m_cnt + 1;
      end
    end
    if (io_wr) m_out_reg = io_wr_data;
    m_t++;
    if (m_t % SCAN_DIV == 0) begin
      m_an  = (m_t / SCAN_DIV) % DIGITS;
      m_seg = 4'((v >> (4 * m_an)) & 32'hF);
    end
    hist.push_back({in, valid, step, run});
    void'(hist.pop_front());
    m_bfd = m_bf;
    m_ifd = m_if;
    uni_b = 1'b1;
    uni_i = 1'b1;
    for (int i = 1; i < DB_CYCLES; i++) begin
      if (hist[i][2:0] != hist[0][2:0]) uni_b = 1'b0;
      if (hist[i][7:3] != hist[0][7:3]) uni_i = 1'b0;
    end
    if (uni_b) m_bf = hist[0][2:0];
    if (uni_i) m_if = hist[0][7:3];
  endtask

  task automatic cyc();
    #1;
    if (io_rd) begin
      rd_seen = io_rd_data;
      chk("io_rd_data", io_rd_data, (m_cnt != 0) ? m_buf : 32'h0);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("check", 32'(check), 32'(m_check));
    chk("out0", 32'(out0), 32'(m_out_reg[OUT_W-1:0]));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
    chk("ready", 32'(ready), 32'(m_cnt != 0));
    chk("cpu_en", 32'(cpu_en), 32'(m_cpu_en));
  endtask

  task automatic press(input logic [IN_W-1:0] v);
    in = v;
    repeat (10) cyc();
    valid = 1'b1;
    repeat (10) cyc();
    valid = 1'b0;
    repeat (10) cyc();
  endtask

  int          lat, pulses;
  logic [3:0]  digs[DIGITS];
  logic [31:0] word;
  logic [3:0]  exp_digs[DIGITS];

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b0; valid = 1'b0; in = '0;
    io_rd = 1'b0; io_wr = 1'b0; io_wr_data = '0; dbg_pc = 32'h0040_1234;
    model_reset();
    repeat (3) cyc();
    chk("rst_check", 32'(check), 0);
    chk("rst_out0", 32'(out0), 0);
    chk("rst_an", 32'(an), 0);
    chk("rst_seg", 32'(seg), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_cpu_en", 32'(cpu_en), 0);
    rst = 1'b0;
    repeat (36) cyc();

    run = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cyc();
      if (cpu_en === 1'b1) lat = i;
    end
    chk("run_rise_latency", 32'(lat), 7);
    repeat (13) cyc();
    run = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cyc();
      if (cpu_en === 1'b0) lat = i;
    end
    chk("run_fall_latency", 32'(lat), 7);
    repeat (10) cyc();

    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      for (int i = 0; i < 10; i++) begin cyc(); if (cpu_en === 1'b1) pulses++; end
      step = 1'b0;
      for (int i = 0; i < 10; i++) begin cyc(); if (cpu_en === 1'b1) pulses++; end
    end
    chk("step_pulses", 32'(pulses), 3);
    pulses = 0;
    step = 1'b1;
    for (int i = 0; i < 2; i++) begin cyc(); if (cpu_en === 1'b1) pulses++; end
    step = 1'b0;
    for (int i = 0; i < 15; i++) begin cyc(); if (cpu_en === 1'b1) pulses++; end
    chk("glitch_pulses", 32'(pulses), 0);

    press(5'b00001);
    press(5'b01111);
    chk("ready_after_entry", 32'(ready), 1);
    io_rd = 1'b1; cyc(); io_rd = 1'b0;
    chk("rd_1f", rd_seen, 32'h0000_001F);
    chk("ready_after_rd", 32'(ready), 0);
    repeat (3) cyc();

    for (int d = 1; d <= 9; d++) press(IN_W'(d));
    in = 5'h0A;
    repeat (10) cyc();
    valid = 1'b1;
    repeat (6) cyc();
    io_rd = 1'b1; cyc(); io_rd = 1'b0;
    chk("rd_full", rd_seen, 32'h2345_6789);
    chk("ready_after_collide", 32'(ready), 1);
    repeat (10) cyc();
    valid = 1'b0;
    repeat (10) cyc();
    io_rd = 1'b1; cyc(); io_rd = 1'b0;
    chk("rd_a", rd_seen, 32'h0000_000A);

    io_wr = 1'b1; io_wr_data = 32'hDEAD_BEEF; cyc(); io_wr = 1'b0;
    chk("out0_wr", 32'(out0), 32'h0F);
    for (int k = 1; k <= 4; k++) begin
      press(5'b10000);
      chk("check_step", 32'(check), 32'(k % 4));
    end
    repeat (40) cyc();
    for (int i = 0; i < DIGITS * SCAN_DIV; i++) begin
      cyc();
      digs[an] = seg;
    end
    word = 32'hDEAD_BEEF;
    for (int i = 0; i < DIGITS; i++) exp_digs[i] = word[i*4 +: 4];
    for (int i = 0; i < DIGITS; i++) chk("seg_view0", 32'(digs[i]), 32'(exp_digs[i]));

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 59) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0) step = ~step;
      if ($urandom_range(0, 7) == 0) valid = ~valid;
      if ($urandom_range(0, 15) == 0) in = IN_W'($urandom);
      io_rd      = ($urandom_range(0, 11) == 0);
      io_wr      = ($urandom_range(0, 19) == 0);
      io_wr_data = $urandom;
      dbg_pc     = $urandom;
      rst        = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
